// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state and command record for the ALU operand issuer
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_NOT  = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_SL   = 4'h8;
   localparam logic [3:0] OP_SR   = 4'h9;
   localparam logic [3:0] OP_LAST = 4'h9;

   // Widest tag the command record can carry; narrower tags are zero-extended.
   localparam int TAG_W_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic [3:0]           op;
      logic [7:0]           a;
      logic [7:0]           b;
      logic [TAG_W_MAX-1:0] tag;
   } cmd_t;

   // Commands the ALU must never see: unknown opcodes and division by zero.
   function automatic logic cmd_illegal(input logic [3:0] op, input logic [7:0] b);
      return (op > OP_LAST) || ((op == OP_DIV) && (b == 8'h00));
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with combinational head
module alu_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - queues tagged ALU commands, drives the ALU one at a time, returns results
module alu_op_issuer
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4,
   parameter int SETTLE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [7:0]        cmd_a,
   input  logic [7:0]        cmd_b,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [7:0]        alu_in1,
   output logic [7:0]        alu_in2,
   output logic [3:0]        alu_sel,
   input  logic [15:0]       alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [15:0]       rsp_result,
   output logic              rsp_err,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   localparam int CNT_W = ($clog2(SETTLE_CYC + 1) < 1) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

   state_t               state;
   logic [CNT_W-1:0]     settle_cnt;
   logic [TAG_W_MAX-1:0] hold_tag;
   logic [TAG_W_MAX-1:0] rsp_tag_q;

   cmd_t                 push_cmd;
   cmd_t                 head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [FCW-1:0]       fifo_count;
   logic                 fifo_pop;
   logic                 unused_tag_hi;

   assign push_cmd = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: TAG_W_MAX'(cmd_tag)};

   assign cmd_ready = !fifo_full;
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign busy      = (fifo_count != '0) || (state != ST_IDLE);
   assign rsp_tag   = rsp_tag_q[TAG_W-1:0];
   assign unused_tag_hi = ^rsp_tag_q;

   alu_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .din   (push_cmd),
      .pop   (fifo_pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ALU ports are only written on a legal pop, so they hold steady outside DRIVE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         hold_tag   <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_sel    <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         rsp_tag_q  <= '0;
         err_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  hold_tag <= head.tag;
                  if (cmd_illegal(head.op, head.b)) begin
                     rsp_valid  <= 1'b1;
                     rsp_err    <= 1'b1;
                     rsp_result <= '0;
                     rsp_tag_q  <= head.tag;
                     if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                     end
                     state <= ST_RESP;
                  end else begin
                     alu_in1    <= head.a;
                     alu_in2    <= head.b;
                     alu_sel    <= head.op;
                     settle_cnt <= CNT_W'(SETTLE_CYC);
                     state      <= ST_DRIVE;
                  end
               end
            end
            ST_DRIVE: begin
               if (settle_cnt == CNT_W'(1)) begin
                  rsp_result <= alu_out;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_tag_q  <= hold_tag;
                  state      <= ST_RESP;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator side of the 8-bit ALU operand/opcode interface. It accepts tagged ALU commands over a valid/ready channel and buffers them in a small FIFO. It drives the ALU's In1/In2/SEL inputs one command at a time, waits a settle window, captures the 16-bit result and returns it with the tag on a valid/ready response channel. Divide-by-zero and undefined opcodes are screened and never issued to the ALU.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2
TAG_W, 4, width of the command/response tag
SETTLE_CYC, 1, cycles ALU inputs are held before capture; >= 1

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command FIFO can accept
cmd_op  in  4  ALU opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NOT, 7 XOR, 8 SL, 9 SR
cmd_a  in  8  operand A (to In1)
cmd_b  in  8  operand B (to In2)
cmd_tag  in  TAG_W  caller tag, returned unchanged
alu_in1  out  8  to ALU In1
alu_in2  out  8  to ALU In2
alu_sel  out  4  to ALU SEL
alu_out  in  16  from ALU out (combinational)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  16  captured ALU result
rsp_err  out  1  1 = command rejected (div-by-zero or opcode >= 10)
rsp_tag  out  TAG_W  tag of the command
busy  out  1  FIFO non-empty or FSM not IDLE
err_cnt  out  8  rejected commands, saturates at 255

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (also mid-operation): FIFO flushed, in-flight command dropped, FSM IDLE. rsp_valid=0, rsp_err=0, rsp_result=0, rsp_tag=0, alu_in1=0, alu_in2=0, alu_sel=0, err_cnt=0, busy=0. cmd_ready is 1 from the first cycle after reset.
- cmd handshake: push when cmd_valid && cmd_ready. cmd_ready = !full, registered-state based and independent of cmd_valid. When the FIFO is full, cmd_ready=0. A push and a pop in the same cycle are both performed, and the count is unchanged.
- FSM states: IDLE, DRIVE, RESP.
- IDLE, FIFO non-empty: pop the head into hold regs (op, a, b, tag).
  - If op >= 10, or op==3 with b==0: go to RESP with rsp_err=1, rsp_result=0x0000. err_cnt increments (saturating). The ALU ports are not updated.
  - Otherwise: load alu_in1=a, alu_in2=b, alu_sel=op, and go to DRIVE with the settle counter set to SETTLE_CYC.
- DRIVE: ALU ports are held constant. The counter decrements each cycle. On the last count, register alu_out into rsp_result, set rsp_err=0 and rsp_valid=1, and go to RESP.
- RESP: rsp_valid=1, and rsp_result/rsp_err/rsp_tag are stable until rsp_ready. On the handshake edge, rsp_valid drops and the FSM goes to IDLE. The next pop occurs in the following cycle, so there is at most one command in flight.
- Outside DRIVE, the ALU ports keep their last driven values (no glitch toggling).
- Latency: from the cmd acceptance edge E0 into an empty FIFO with the FSM IDLE, the pop occurs at E1. rsp_valid rises at edge E(1+SETTLE_CYC) for a legal command, and at E1 for a rejected command.
- Throughput: one command per SETTLE_CYC+2 cycles when rsp_ready is held high.
- Results are taken verbatim from the ALU (16-bit, unsigned-operand semantics). The issuer performs no arithmetic on the result.
- Response order is strictly the command order.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ADD..SR, 4'h0..4'h9)
  - OP_LAST = 4'h9
  - state enum type (IDLE/DRIVE/RESP)
  - cmd struct {op, a, b, tag}
- Sub-module alu_cmd_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, the same synchronous reset, and no read latency (head is visible combinationally). It is instantiated once.

Test Plan:
- ADD a=0xFF b=0x01 tag=3, rsp_ready=1, SETTLE_CYC=1 -> rsp_valid at E2, rsp_result=0x0100, rsp_err=0, rsp_tag=3.
- SUB a=0x03 b=0x05; MUL a=0xFF b=0xFF; SL a=0x81 b=4; NOT a=0x0F -> responses in order: 0xFFFE, 0xFE01, 0x0810, 0x00F0.
- DIV a=0x07 b=0x00, then opcode 0xC -> both give rsp_err=1, rsp_result=0x0000, rsp_valid at E1, alu_sel unchanged, err_cnt=2; then DIV 0x64/0x07 -> 0x000E, rsp_err=0.
- rsp_ready=0 while pushing 6 commands -> cmd_ready falls after FIFO_DEPTH pushes plus the 1 in flight. The rsp_* fields stay stable. Releasing rsp_ready drains all results in order with correct tags.
- rst asserted for 1 cycle while in DRIVE with 3 queued -> next cycle all outputs are at reset values, busy=0, and no response is ever emitted for the dropped commands.
- 300 back-to-back DIV-by-zero commands -> err_cnt saturates at 255.
